dmem_arbiter: RTL and testbench

Shares the byte-addressed data memory between two requesters: port A (pipeline MEM stage) and port B (loader/debug port). It arbitrates round-robin, latches the winner's command, and sequences the memory's `R1`/`D1`/`We`/`Re` pins. Address and data change only while `We` is low and stay stable across a full write cycle, so the level-sensitive memory never sees a glitching write. Every accepted request returns a one-cycle `done` with read data or an error flag.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Interfaces used by dmem_arbiter.
//
// dmem_req_if : one requester's command/response port.
//   req, we, addr, wdata   requester -> arbiter (command, held until gnt)
//   gnt, done, err, rdata  arbiter -> requester (accept pulse, completion)
//   modports: master (requester side), slave (arbiter side)
//
// dmem_mem_if : pins of the level-sensitive data memory.
//   addr (R1), wdata (D1), we (We), re (Re)  arbiter -> memory
//   rdata (O1)                               memory -> arbiter
//   modports: master (arbiter side), slave (memory side)
interface dmem_req_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, err, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, err, rdata);
endinterface

interface dmem_mem_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one byte-addressed data memory
// between requester A (pipeline MEM stage) and requester B (loader/debug).
// The winner's command is latched on the accept edge; address and write
// data reach the memory pins only on that edge, so they are stable for the
// whole write pulse and the level-sensitive memory never sees a glitch.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   a, b   dmem_req_if.slave   requester ports (req/we/addr/wdata in,
//                              gnt/done/err/rdata out)
//   mem    dmem_mem_if.master  memory pins (addr/wdata/we/re out, rdata in)
module dmem_arbiter #(
  parameter int MEM_BYTES = 256,
  parameter int DATA_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_req_if.slave  a,
  dmem_req_if.slave  b,
  dmem_mem_if.master mem
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic        SEL_A     = 1'b0;
  localparam logic        SEL_B     = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    WR_HOLD = 3'd3,
    ERR     = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_sel is the port of the transaction in flight; it also serves as the
  // round-robin "last granted" record, since it is rewritten on every accept
  // and held otherwise.
  logic              r_sel;
  logic              r_err;
  logic [31:0]       r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_pick_b;
  logic              w_we;
  logic              w_bad;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_gnt;
  logic              w_done;
  logic              w_mem_we;
  logic              w_mem_re;

  // B wins when it is alone, or on a tie when A was granted last.
  assign w_pick_b = b.req && (!a.req || (r_sel == SEL_A));
  assign w_accept = (r_state == IDLE) && (a.req || b.req);
  assign w_we     = w_pick_b ? b.we    : a.we;
  assign w_addr   = w_pick_b ? b.addr  : a.addr;
  assign w_wdata  = w_pick_b ? b.wdata : a.wdata;
  assign w_bad    = (w_addr[1:0] != 2'b00) || (w_addr > LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_gnt    = 1'b0;
    w_done   = 1'b0;
    w_mem_we = 1'b0;
    w_mem_re = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_next = ERR;
          end else if (w_we) begin
            w_next = WR;
          end else begin
            w_next = RD;
          end
        end
      end
      RD: begin
        w_mem_re = 1'b1;
        w_gnt    = 1'b1;
        w_next   = RESP;
      end
      WR: begin
        w_mem_we = 1'b1;
        w_gnt    = 1'b1;
        w_next   = WR_HOLD;
      end
      // We is low here while address/data are unchanged, closing the write
      // window cleanly before anything on the pins may move.
      WR_HOLD: begin
        w_next = RESP;
      end
      ERR: begin
        w_gnt  = 1'b1;
        w_next = RESP;
      end
      RESP: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Command latch and response capture. r_rdata is cleared on accept so
  // writes and errors answer with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= SEL_B;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else if (w_accept) begin
      r_sel       <= w_pick_b;
      r_err       <= w_bad;
      r_mem_addr  <= w_addr;
      r_mem_wdata <= w_wdata;
      r_rdata     <= '0;
    end else if (r_state == RD) begin
      r_rdata <= mem.rdata;
    end
  end

  // Control outputs decode straight from state, so an asynchronous reset
  // clears them at once without waiting for a clock edge.
  assign mem.addr  = r_mem_addr;
  assign mem.wdata = r_mem_wdata;
  assign mem.we    = w_mem_we;
  assign mem.re    = w_mem_re;

  assign a.gnt   = w_gnt  && (r_sel == SEL_A);
  assign a.done  = w_done && (r_sel == SEL_A);
  assign a.err   = w_done && r_err && (r_sel == SEL_A);
  assign a.rdata = (w_done && (r_sel == SEL_A)) ? r_rdata : '0;

  assign b.gnt   = w_gnt  && (r_sel == SEL_B);
  assign b.done  = w_done && (r_sel == SEL_B);
  assign b.err   = w_done && r_err && (r_sel == SEL_B);
  assign b.rdata = (w_done && (r_sel == SEL_B)) ? r_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized transactions, checked against a behavioural memory/arbiter
// model (expected memory image, last-granted port, latency rules).
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 256;
  localparam int DATA_W    = 32;
  localparam int WORDS     = MEM_BYTES / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_req_if #(.DATA_W(DATA_W)) a_if ();
  dmem_req_if #(.DATA_W(DATA_W)) b_if ();
  dmem_mem_if #(.DATA_W(DATA_W)) m_if ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_if),
    .b     (b_if),
    .mem   (m_if)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory environment: level-sensitive array, loaded once with a pattern.
  logic [DATA_W-1:0] phys_mem [WORDS];
  logic              mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < WORDS; i++) phys_mem[i] <= 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      mem_ready <= 1'b1;
    end else if (m_if.we) begin
      phys_mem[m_if.addr[7:2]] <= m_if.wdata;
    end
  end
  assign m_if.rdata = m_if.re ? phys_mem[m_if.addr[7:2]] : 32'hBAD0_BAD0;

  int we_cycles = 0;
  int re_cycles = 0;
  always @(negedge clk) begin
    if (m_if.we) we_cycles++;
    if (m_if.re) re_cycles++;
    if (rst_n) chk("we_re_exclusive", 64'(m_if.we & m_if.re), 64'd0);
  end

  // Reference model state.
  logic [31:0] exp_mem [WORDS];
  bit          exp_last;   // 0 = A, 1 = B

  task automatic drive(input bit p, input logic r, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (!p) begin
      a_if.req = r; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
    end else begin
      b_if.req = r; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? b_if.gnt : a_if.gnt;
  endfunction
  function automatic logic done_of(input bit p);
    return p ? b_if.done : a_if.done;
  endfunction
  function automatic logic err_of(input bit p);
    return p ? b_if.err : a_if.err;
  endfunction
  function automatic logic [31:0] rdata_of(input bit p);
    return p ? b_if.rdata : a_if.rdata;
  endfunction

  function automatic bit addr_bad(input logic [31:0] addr);
    return ((addr % 4) != 0) || ((longint'(addr) + 4) > MEM_BYTES);
  endfunction

  // One transaction from an idle arbiter; called at a negedge in IDLE.
  task automatic do_txn(input bit p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    bit          e;
    logic [31:0] er;
    int          el, gc, dc, we0, re0;
    logic        got_err;
    logic [31:0] got_rd, gnt_addr, gnt_wd, c2_addr;
    logic        c2_we;
    bit          noise;
    e  = addr_bad(addr);
    er = '0;
    if (!e && !we) er = exp_mem[addr / 4];
    el = (e || !we) ? 2 : 3;
    gc = -1; dc = -1; got_err = 1'bx; got_rd = 'x;
    gnt_addr = 'x; gnt_wd = 'x; c2_addr = 'x; c2_we = 1'bx; noise = 0;
    we0 = we_cycles; re0 = re_cycles;
    drive(p, 1'b1, we, addr, wd);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      noise |= gnt_of(!p) | done_of(!p) | err_of(!p) | (|rdata_of(!p));
      if (gnt_of(p) && gc < 0) begin
        gc = c; gnt_addr = m_if.addr; gnt_wd = m_if.wdata;
        drive(p, 1'b0, we, addr, wd);
      end
      if (c == 2) begin
        c2_addr = m_if.addr; c2_we = m_if.we;
      end
      if (done_of(p)) begin
        dc = c; got_err = err_of(p); got_rd = rdata_of(p);
        break;
      end
    end
    drive(p, 1'b0, we, addr, wd);
    @(negedge clk);
    chk({tag, " gnt_latency"}, 64'(gc), 64'd1);
    chk({tag, " done_latency"}, 64'(dc), 64'(el));
    chk({tag, " err"}, 64'(got_err), 64'(e));
    chk({tag, " rdata"}, 64'(got_rd), 64'(er));
    chk({tag, " other_port_quiet"}, 64'(noise), 64'd0);
    chk({tag, " we_cycles"}, 64'(we_cycles - we0), 64'((!e && we) ? 1 : 0));
    chk({tag, " re_cycles"}, 64'(re_cycles - re0), 64'((!e && !we) ? 1 : 0));
    if (!e) chk({tag, " mem_addr_at_gnt"}, 64'(gnt_addr), 64'(addr));
    if (!e && we) begin
      chk({tag, " mem_wdata_at_gnt"}, 64'(gnt_wd), 64'(wd));
      chk({tag, " mem_addr_in_hold"}, 64'(c2_addr), 64'(addr));
      chk({tag, " we_low_in_hold"}, 64'(c2_we), 64'd0);
      exp_mem[addr / 4] = wd;
    end
    exp_last = p;
  endtask

  // Both ports issue a read in the same idle cycle; the loser keeps req high.
  task automatic tie_read(input logic [31:0] addr_a, input logic [31:0] addr_b, input string tag);
    bit   first;
    int   order [2];
    int   ng, nd;
    logic [31:0] rd [2];
    first = !exp_last;
    ng = 0; nd = 0;
    rd[0] = 'x; rd[1] = 'x; order[0] = -1; order[1] = -1;
    drive(0, 1'b1, 1'b0, addr_a, '0);
    drive(1, 1'b1, 1'b0, addr_b, '0);
    for (int c = 1; c <= 16 && nd < 2; c++) begin
      @(negedge clk);
      if (a_if.gnt && ng < 2) begin order[ng] = 0; ng++; drive(0, 1'b0, 1'b0, addr_a, '0); end
      if (b_if.gnt && ng < 2) begin order[ng] = 1; ng++; drive(1, 1'b0, 1'b0, addr_b, '0); end
      if (a_if.done) begin rd[0] = a_if.rdata; nd++; end
      if (b_if.done) begin rd[1] = b_if.rdata; nd++; end
    end
    drive(0, 1'b0, 1'b0, addr_a, '0);
    drive(1, 1'b0, 1'b0, addr_b, '0);
    @(negedge clk);
    chk({tag, " first_grant"}, 64'(order[0]), 64'(first));
    chk({tag, " second_grant"}, 64'(order[1]), 64'(!first));
    chk({tag, " a_rdata"}, 64'(rd[0]), 64'(exp_mem[addr_a / 4]));
    chk({tag, " b_rdata"}, 64'(rd[1]), 64'(exp_mem[addr_b / 4]));
    exp_last = !first;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k <= 6) return {22'd0, 8'($urandom_range(0, WORDS - 1)), 2'b00};
    if (k == 7) return {22'd0, 8'($urandom_range(0, WORDS - 1)), 2'($urandom_range(1, 3))};
    if (k == 8) return 32'($urandom_range(MEM_BYTES, 4096)) & 32'hFFFF_FFFC;
    return 32'(MEM_BYTES - 4);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a_after, b_at, quiet;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    exp_last = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset mem_addr", 64'(m_if.addr), 64'd0);
    chk("reset mem_we_re", 64'({m_if.we, m_if.re}), 64'd0);
    chk("reset outputs", 64'({a_if.gnt, a_if.done, a_if.err, b_if.gnt, b_if.done, b_if.err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie after reset: A, B, then A again.
    tie_read(32'h04, 32'h08, "tie1");
    tie_read(32'h0C, 32'h10, "tie2");

    // Write then read by A.
    do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "a_write");
    do_txn(0, 1'b0, 32'h10, '0, "a_read");

    // Error cases and the last legal word.
    do_txn(0, 1'b0, 32'h13, '0, "err_misaligned");
    do_txn(0, 1'b0, 32'h100, '0, "err_range");
    do_txn(0, 1'b0, 32'hFC, '0, "read_fc");

    // Port B write, A read-back.
    do_txn(1, 1'b1, 32'hFC, 32'h0102_0304, "b_write");
    do_txn(0, 1'b0, 32'hFC, '0, "a_read_fc");

    // Starvation: A holds req continuously, B asks once.
    a_after = 0; b_at = -1;
    drive(0, 1'b1, 1'b0, 32'h20, '0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) drive(1, 1'b1, 1'b0, 32'h24, '0);
      if (c > 3 && b_at < 0 && a_if.gnt) a_after++;
      if (b_if.gnt && b_at < 0) begin b_at = c; drive(1, 1'b0, 1'b0, 32'h24, '0); end
    end
    drive(0, 1'b0, 1'b0, 32'h20, '0);
    repeat (6) @(negedge clk);
    chk("starve b_granted", 64'(b_at > 0), 64'd1);
    chk("starve a_grants_before_b", 64'(a_after <= 1), 64'd1);

    // Reset in the middle of a write.
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1122_3344);
    @(negedge clk);
    chk("rst_mid wr_active", 64'(m_if.we), 64'd1);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h1122_3344);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid we_async", 64'(m_if.we), 64'd0);
    chk("rst_mid gnt_async", 64'({a_if.gnt, b_if.gnt, m_if.re}), 64'd0);
    chk("rst_mid addr_data", 64'({m_if.addr, m_if.wdata}), 64'd0);
    quiet = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      quiet += int'(a_if.done | b_if.done | a_if.gnt | b_if.gnt | (|a_if.rdata));
    end
    chk("rst_mid no_done", 64'(quiet), 64'd0);
    do_txn(0, 1'b0, 32'h00, '0, "rst_read0");

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(), "rand");
      end else begin
        tie_read({22'd0, 8'($urandom_range(0, WORDS - 1)), 2'b00},
                 {22'd0, 8'($urandom_range(0, WORDS - 1)), 2'b00}, "rand_tie");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
